// File: rtl/multiexp_feeder_pkg.sv
// Shared types for the multiexp point/scalar feeder: field element, Jacobian point, packed pair, FSM states.
package multiexp_feeder_pkg;

   localparam int FE_BITS = 256;

   typedef logic [FE_BITS-1:0] fe_t;

   typedef struct packed {
      fe_t x;
      fe_t y;
      fe_t z;
   } jb_point_t;

   typedef struct packed {
      jb_point_t pnt;
      fe_t       scl;
   } pnt_scl_t;

   typedef enum logic {
      ST_LOAD   = 1'b0,
      ST_STREAM = 1'b1
   } feed_state_e;

endpackage

// File: rtl/multiexp_feeder_buf.sv
// NUM_IN-entry pair register file: one write port, one registered read port.
// A read of the entry being written in the same cycle returns the new data.
module multiexp_feeder_buf #(
   parameter int W  = 1024,
   parameter int N  = 4,
   parameter int AW = 2
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [W-1:0]  i_wr_dat,
   input  logic          i_rd_en,
   input  logic [AW-1:0] i_rd_addr,
   output logic [W-1:0]  o_rd_dat
);

   logic [W-1:0] mem_q [N];
   logic [W-1:0] rd_dat_q;

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         mem_q[i_wr_addr] <= i_wr_dat;
      end
   end

   // Bypass covers NUM_IN=1, where entry 0 is read on the edge that writes it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_dat_q <= '0;
      end else if (i_rd_en) begin
         rd_dat_q <= (i_wr_en && (i_wr_addr == i_rd_addr)) ? i_wr_dat : mem_q[i_rd_addr];
      end
   end

   assign o_rd_dat = rd_dat_q;

endmodule

// File: rtl/multiexp_feeder.sv
// Loads NUM_IN {point, scalar} pairs, then replays them DAT_BITS times round-major / pair-minor.
// MULTIEXP_FEEDER_SCALAR_SHIFT_EN: scalar output is shifted left by the round index (MSB-first key bit).
module multiexp_feeder
   import multiexp_feeder_pkg::*;
#(
   parameter int DAT_BITS = $bits(fe_t),
   parameter int PNT_BITS = $bits(jb_point_t),
   parameter int NUM_IN   = 4,
   parameter int CTL_BITS = 8
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [PNT_BITS+DAT_BITS-1:0] i_dat,
   input  logic                         i_val,
   input  logic                         i_eop,
   output logic                         o_rdy,
   output logic [PNT_BITS+DAT_BITS-1:0] o_dat,
   output logic                         o_val,
   input  logic                         i_rdy,
   output logic                         o_sop,
   output logic                         o_eop,
   output logic [CTL_BITS-1:0]          o_ctl,
   output logic                         o_busy,
   output logic                         o_err
);

   localparam int W  = PNT_BITS + DAT_BITS;
   localparam int IW = $clog2(NUM_IN) + 1;
   localparam int RW = $clog2(DAT_BITS) + 1;
   localparam int AW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   feed_state_e   state_q, state_d;
   logic [IW-1:0] wr_idx_q, wr_idx_d;
   logic [IW-1:0] i_q, i_d, i_nxt;
   logic [RW-1:0] r_q, r_d, r_nxt;
   logic          val_q, val_d;
   logic          sop_q, sop_d;
   logic          eop_q, eop_d;
   logic          rdy_q, rdy_d;
   logic          busy_q, busy_d;
   logic          err_q, err_d;

   logic          ld_fire, ld_last, out_fire;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [W-1:0]  rd_dat;

   assign ld_fire  = i_val && rdy_q && (state_q == ST_LOAD);
   assign ld_last  = (wr_idx_q == IW'(NUM_IN - 1));
   assign out_fire = val_q && i_rdy;

   assign i_nxt = (i_q == IW'(NUM_IN - 1)) ? '0 : i_q + 1'b1;
   assign r_nxt = (i_q == IW'(NUM_IN - 1)) ? r_q + 1'b1 : r_q;

   always_comb begin
      state_d  = state_q;
      wr_idx_d = wr_idx_q;
      i_d      = i_q;
      r_d      = r_q;
      val_d    = val_q;
      sop_d    = sop_q;
      eop_d    = eop_q;
      rdy_d    = rdy_q;
      busy_d   = busy_q;
      err_d    = err_q;
      rd_en    = 1'b0;
      rd_addr  = i_nxt[AW-1:0];
      case (state_q)
         ST_LOAD: begin
            rdy_d = 1'b1;
            if (ld_fire) begin
               busy_d = 1'b1;
               if (i_eop != ld_last) begin
                  err_d = 1'b1;
               end
               if (ld_last) begin
                  // Prefetch pair 0 so the first beat is valid on the next cycle.
                  state_d  = ST_STREAM;
                  wr_idx_d = '0;
                  rdy_d    = 1'b0;
                  val_d    = 1'b1;
                  i_d      = '0;
                  r_d      = '0;
                  sop_d    = 1'b1;
                  eop_d    = 1'(NUM_IN == 1 && DAT_BITS == 1);
                  rd_en    = 1'b1;
                  rd_addr  = '0;
               end else begin
                  wr_idx_d = wr_idx_q + 1'b1;
               end
            end
         end
         ST_STREAM: begin
            if (out_fire) begin
               if (eop_q) begin
                  state_d = ST_LOAD;
                  val_d   = 1'b0;
                  sop_d   = 1'b0;
                  eop_d   = 1'b0;
                  busy_d  = 1'b0;
                  rdy_d   = 1'b1;
                  i_d     = '0;
                  r_d     = '0;
               end else begin
                  i_d   = i_nxt;
                  r_d   = r_nxt;
                  sop_d = 1'b0;
                  eop_d = (r_nxt == RW'(DAT_BITS - 1)) && (i_nxt == IW'(NUM_IN - 1));
                  rd_en = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ST_LOAD;
         wr_idx_q <= '0;
         i_q      <= '0;
         r_q      <= '0;
         val_q    <= 1'b0;
         sop_q    <= 1'b0;
         eop_q    <= 1'b0;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_idx_q <= wr_idx_d;
         i_q      <= i_d;
         r_q      <= r_d;
         val_q    <= val_d;
         sop_q    <= sop_d;
         eop_q    <= eop_d;
         rdy_q    <= rdy_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   multiexp_feeder_buf #(
      .W  (W),
      .N  (NUM_IN),
      .AW (AW)
   ) u_buf (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_wr_en   (ld_fire),
      .i_wr_addr (wr_idx_q[AW-1:0]),
      .i_wr_dat  (i_dat),
      .i_rd_en   (rd_en),
      .i_rd_addr (rd_addr),
      .o_rd_dat  (rd_dat)
   );

`ifdef MULTIEXP_FEEDER_SCALAR_SHIFT_EN
   assign o_dat = {rd_dat[W-1:DAT_BITS], rd_dat[DAT_BITS-1:0] << r_q};
`else
   assign o_dat = rd_dat;
`endif

   assign o_val  = val_q;
   assign o_sop  = sop_q;
   assign o_eop  = eop_q;
   assign o_ctl  = CTL_BITS'(r_q);
   assign o_rdy  = rdy_q;
   assign o_busy = busy_q;
   assign o_err  = err_q;

endmodule

// File: tb/tb_multiexp_feeder.sv
// Self-checking bench for multiexp_feeder at DAT_BITS=8, NUM_IN=2: table of batches plus reset/framing sequences.
module tb_multiexp_feeder;

   localparam int DB = 8;
   localparam int NI = 2;
   localparam int PB = 16;
   localparam int CB = 8;
   localparam int W  = PB + DB;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic [W-1:0]  i_dat = '0;
   logic          i_val = 1'b0;
   logic          i_eop = 1'b0;
   logic          i_rdy = 1'b0;
   logic          o_rdy, o_val, o_sop, o_eop, o_busy, o_err;
   logic [W-1:0]  o_dat;
   logic [CB-1:0] o_ctl;

   int total = 0;
   int bad   = 0;

   multiexp_feeder #(
      .DAT_BITS (DB),
      .PNT_BITS (PB),
      .NUM_IN   (NI),
      .CTL_BITS (CB)
   ) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_dat   (i_dat),
      .i_val   (i_val),
      .i_eop   (i_eop),
      .o_rdy   (o_rdy),
      .o_dat   (o_dat),
      .o_val   (o_val),
      .i_rdy   (i_rdy),
      .o_sop   (o_sop),
      .o_eop   (o_eop),
      .o_ctl   (o_ctl),
      .o_busy  (o_busy),
      .o_err   (o_err)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [W-1:0]  dat;
      logic [CB-1:0] ctl;
      logic          sop;
      logic          eop;
   } beat_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [1:0]   eop_pat;
      int           rdy_mode;
      logic         exp_err;
   } vec_t;

   beat_t expq[$];
   vec_t  vt[6];

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      total++;
      bad++;
      $display("FAIL %s: timed out waiting for DUT", nm);
   endtask

   // Reference: scalar of pair p as presented in round r.
   function automatic logic [W-1:0] model_dat(input logic [W-1:0] p, input int r);
      logic [DB-1:0] s;
      s = p[DB-1:0];
`ifdef MULTIEXP_FEEDER_SCALAR_SHIFT_EN
      s = s << r;
`endif
      return {p[W-1:DB], s};
   endfunction

   task automatic build_exp(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] pr[NI];
      beat_t bt;
      pr[0] = a;
      pr[1] = b;
      expq.delete();
      for (int r = 0; r < DB; r++) begin
         for (int k = 0; k < NI; k++) begin
            bt.dat = model_dat(pr[k], r);
            bt.ctl = CB'(r);
            bt.sop = 1'b0;
            bt.eop = 1'b0;
            expq.push_back(bt);
         end
      end
      expq[0].sop = 1'b1;
      expq[expq.size()-1].eop = 1'b1;
   endtask

   // Called at a negedge; returns at the negedge after the last beat is accepted.
   task automatic load_pair(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] ep);
      int n;
      for (int k = 0; k < NI; k++) begin
         i_val = 1'b1;
         i_dat = (k == 0) ? a : b;
         i_eop = ep[k];
         n = 0;
         while (!o_rdy && n < 50) begin
            @(negedge i_clk);
            n++;
         end
         if (n >= 50) timeout("load_rdy");
         @(negedge i_clk);
         if (k == 0) chk("busy_after_first_load", W'(o_busy), W'(1));
      end
      i_val = 1'b0;
      i_eop = 1'b0;
   endtask

   task automatic stream_check(input int mode, input string nm);
      int k = 0;
      int n = 0;
      bit done = 0;
      logic pv = 1'b0;
      logic pr = 1'b0;
      logic [W-1:0] pd = '0;
      logic ps = 1'b0;
      logic pe = 1'b0;
      logic [CB-1:0] pc = '0;
      chk({nm, "_first_val"}, W'(o_val), W'(1));
      while (!done && n < 300) begin
         i_rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((n % 2) == 0) : 1'($urandom_range(0, 1));
         chk({nm, "_rdy_low"}, W'(o_rdy), W'(0));
         if (pv && !pr) begin
            chk({nm, "_stall_dat"}, o_dat, pd);
            chk({nm, "_stall_sop"}, W'(o_sop), W'(ps));
            chk({nm, "_stall_eop"}, W'(o_eop), W'(pe));
            chk({nm, "_stall_ctl"}, W'(o_ctl), W'(pc));
         end
         if (o_val && i_rdy) begin
            if (k < expq.size()) begin
               chk({nm, "_dat"}, o_dat, expq[k].dat);
               chk({nm, "_ctl"}, W'(o_ctl), W'(expq[k].ctl));
               chk({nm, "_sop"}, W'(o_sop), W'(expq[k].sop));
               chk({nm, "_eop"}, W'(o_eop), W'(expq[k].eop));
               if (expq[k].eop) done = 1;
            end else begin
               chk({nm, "_extra_beat"}, W'(k), W'(expq.size()));
               done = 1;
            end
            k++;
         end
         pv = o_val;
         pr = i_rdy;
         pd = o_dat;
         ps = o_sop;
         pe = o_eop;
         pc = o_ctl;
         @(negedge i_clk);
         n++;
      end
      i_rdy = 1'b0;
      if (!done) timeout({nm, "_stream"});
      chk({nm, "_beat_count"}, W'(k), W'(expq.size()));
      chk({nm, "_val_after_eop"}, W'(o_val), W'(0));
      chk({nm, "_busy_after_eop"}, W'(o_busy), W'(0));
      chk({nm, "_rdy_after_eop"}, W'(o_rdy), W'(1));
   endtask

   initial begin
      vt[0] = '{a: W'($urandom), b: W'($urandom), eop_pat: 2'b10, rdy_mode: 0, exp_err: 1'b0};
      vt[1] = '{a: W'($urandom), b: W'($urandom), eop_pat: 2'b10, rdy_mode: 1, exp_err: 1'b0};
      vt[2] = '{a: W'($urandom), b: W'($urandom), eop_pat: 2'b10, rdy_mode: 2, exp_err: 1'b0};
      vt[3] = '{a: W'($urandom), b: W'($urandom), eop_pat: 2'b11, rdy_mode: 0, exp_err: 1'b1};
      vt[4] = '{a: W'($urandom), b: W'($urandom), eop_pat: 2'b10, rdy_mode: 2, exp_err: 1'b1};
      vt[5] = '{a: {16'h1234, 8'h81}, b: {16'hbeef, 8'hff}, eop_pat: 2'b10, rdy_mode: 0, exp_err: 1'b1};

      #1;
      chk("rst_val", W'(o_val), W'(0));
      chk("rst_rdy", W'(o_rdy), W'(0));
      chk("rst_dat", o_dat, W'(0));
      chk("rst_sop", W'(o_sop), W'(0));
      chk("rst_eop", W'(o_eop), W'(0));
      chk("rst_ctl", W'(o_ctl), W'(0));
      chk("rst_busy", W'(o_busy), W'(0));
      chk("rst_err", W'(o_err), W'(0));
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      chk("rdy_after_rst", W'(o_rdy), W'(1));

      for (int t = 0; t < 6; t++) begin
         build_exp(vt[t].a, vt[t].b);
         load_pair(vt[t].a, vt[t].b, vt[t].eop_pat);
         stream_check(vt[t].rdy_mode, $sformatf("vec%0d", t));
         chk($sformatf("vec%0d_err", t), W'(o_err), W'(vt[t].exp_err));
      end

      // Mid-stream reset after five accepted beats.
      build_exp(W'($urandom), W'($urandom));
      load_pair(expq[0].dat, expq[1].dat, 2'b10);
      i_rdy = 1'b1;
      for (int k = 0; k < 5; k++) @(negedge i_clk);
      chk("mid_ctl_after5", W'(o_ctl), W'(2));
      chk("mid_val_before_rst", W'(o_val), W'(1));
      #2 i_rst_n = 1'b0;
      #1;
      chk("mid_val_in_rst", W'(o_val), W'(0));
      chk("mid_err_in_rst", W'(o_err), W'(0));
      i_rdy = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      chk("mid_rdy_after_rel", W'(o_rdy), W'(1));
      chk("mid_busy_after_rel", W'(o_busy), W'(0));

      // Fresh batch after the reset: stream restarts at sop with round 0.
      build_exp(W'($urandom), W'($urandom));
      load_pair(expq[0].dat, expq[1].dat, 2'b10);
      chk("fresh_sop", W'(o_sop), W'(1));
      chk("fresh_ctl", W'(o_ctl), W'(0));
      stream_check(2, "fresh");
      chk("fresh_err", W'(o_err), W'(0));

      // Final beat without eop is a framing error too.
      build_exp(W'($urandom), W'($urandom));
      load_pair(expq[0].dat, expq[1].dat, 2'b00);
      stream_check(0, "noeop");
      chk("noeop_err", W'(o_err), W'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multiexp_feeder.md
Name: multiexp_feeder

Overview:
- Source-side sequencer for the multiexp core's point/scalar input stream.
- Loads NUM_IN {point, scalar} pairs from an upstream AXI-stream-style sink into a local buffer.
- Replays the full set DAT_BITS times on its output stream, in the beat order the multiexp core consumes: round-major, pair-minor.
- Sits between the host/DMA loader and the multiexp input interface.

Parameters:
- DAT_BITS, 256: scalar width; also the number of replay rounds.
- PNT_BITS, 768: Jacobian point width (3 x 256).
- NUM_IN, 4: pairs per batch; must be >= 1.
- CTL_BITS, 8: width of the output ctl field.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_dat  in  PNT_BITS+DAT_BITS  load pair {point[PNT_BITS-1:0], scalar[DAT_BITS-1:0]}; point in the high bits
- i_val  in  1  load beat valid
- i_eop  in  1  load beat marked last by the sender
- o_rdy  out  1  load ready
- o_dat  out  PNT_BITS+DAT_BITS  output pair, same packing as i_dat
- o_val  out  1  output valid
- i_rdy  in  1  downstream ready
- o_sop  out  1  first beat of the batch stream
- o_eop  out  1  last beat of the batch stream
- o_ctl  out  CTL_BITS  current round index, truncated to CTL_BITS
- o_busy  out  1  high from the first accepted load beat until the output eop is accepted
- o_err  out  1  sticky load-framing error

Behaviour:
- Reset: asynchronous, active-low. All outputs 0; state LOAD; all counters 0.
  - Asserting i_rst_n low mid-stream drops o_val in the same cycle. No partial completion.
- Beat transfer:
  - Load beat transfers when i_val && o_rdy.
  - Output beat transfers when o_val && i_rdy.
  - o_dat, o_sop, o_eop and o_ctl are held stable while o_val && !i_rdy.
- State LOAD:
  - o_rdy=1, o_val=0.
  - Each accepted beat is written to buf[wr_idx]; wr_idx increments.
  - On acceptance of beat NUM_IN-1: wr_idx wraps to 0, go to STREAM.
- Load framing:
  - i_eop on a beat other than index NUM_IN-1 sets o_err. The beat is still stored and loading continues.
  - Beat NUM_IN-1 without i_eop also sets o_err.
  - o_err clears only on reset.
- State STREAM:
  - o_rdy=0. Counters: pair index i (0..NUM_IN-1), round r (0..DAT_BITS-1).
  - Output registered: the first beat has o_val=1 on the cycle after the final load acceptance.
  - Each beat: o_dat=buf[i]; o_ctl=r[CTL_BITS-1:0]; o_sop=(r==0 && i==0); o_eop=(r==DAT_BITS-1 && i==NUM_IN-1).
  - On each transfer, i increments. When i wraps from NUM_IN-1 to 0, r increments.
  - Throughput: one beat per cycle while i_rdy is held high. Total NUM_IN*DAT_BITS beats.
  - NUM_IN=1: o_sop and o_eop may be asserted on the same beat only if DAT_BITS=1.
- Completion: on transfer of the eop beat, o_val falls next cycle, o_busy falls, return to LOAD, o_rdy=1 next cycle.
- Load handshake outside LOAD: i_val while in STREAM is ignored (o_rdy=0). No beat is lost, because the sender holds the beat until o_rdy.
- Widths: r is $clog2(DAT_BITS)+1 bits and i is $clog2(NUM_IN)+1 bits, so the terminal compare never overflows.
- Buffer: NUM_IN x (PNT_BITS+DAT_BITS) registers, write-only in LOAD, read-only in STREAM.

Optional Feature:
- Macro: MULTIEXP_FEEDER_SCALAR_SHIFT_EN.
- Defined: the scalar field of o_dat is buf[i].scalar << r, zero-filled. Bit DAT_BITS-1 is therefore the key bit consumed in round r, MSB-first. The point field is unchanged.
- Undefined: the scalar is passed unmodified every round; the core does its own bit selection.

Decomposition:
- bn128_pkg (existing) supplies fe_t and jb_point_t. Defaults derive from $bits(fe_t) and $bits(jb_point_t).
- New typedef pnt_scl_t = struct packed {jb_point_t pnt; fe_t scl;} goes in common_pkg.
- One sub-module, multiexp_feeder_buf: NUM_IN-entry register file with one write port and one registered read port. The FSM and counters stay in the top.

Test Plan:
1. DAT_BITS=8, NUM_IN=2; load pairs A,B with eop on B; i_rdy=1.
   - 16 beats back-to-back: A,B,A,B,...
   - o_ctl 0,0,1,1,...,7,7; o_sop only on beat 0; o_eop only on beat 15; o_err=0.
2. Same as 1 with i_rdy toggling 1-0.
   - o_dat, o_sop and o_eop stable through each stall; exactly 16 transfers.
   - o_busy falls the cycle after the eop transfer.
3. Full-scale NUM_IN=4, DAT_BITS=256 with random G1 multiples and keys; output driven into multiexp_top.
   - 1024 beats; core result equals the software multiexp_parallel_batch reference.
4. Load with i_eop on beat 0 of 2 → o_err=1 and streaming still proceeds. Next batch loaded correctly → o_err stays 1 until reset.
5. Pull i_rst_n low after 5 output beats.
   - o_val=0 immediately; after release o_rdy=1, o_busy=0.
   - A fresh load streams from o_sop with o_ctl=0.
6. With SCALAR_SHIFT_EN, DAT_BITS=8, scalar 0x81: rounds 0,1,7 output 0x81, 0x02, 0x80.
